// File: rtl/axc_booth_pkg.sv
// Shared types for the tunable-accuracy radix-2 Booth multiplier:
// Booth digit encoding, FSM states and the digit decoder.
package axc_booth_pkg;

  typedef enum logic [1:0] {
    DIGIT_ZERO = 2'b00,
    DIGIT_POS  = 2'b01,
    DIGIT_NEG  = 2'b11
  } booth_digit_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Radix-2 Booth digit d = a[i-1] - a[i]
  function automatic booth_digit_e booth_decode(input logic a_cur, input logic a_prev);
    case ({a_cur, a_prev})
      2'b01:   return DIGIT_POS;
      2'b10:   return DIGIT_NEG;
      default: return DIGIT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/axc_booth_mul_digit.sv
// Combinational radix-2 Booth digit: yields d*B (0, B or -B) for the
// operand bit pair a[i], a[i-1].
module booth_r2_digit
  import axc_booth_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         a_cur,
  input  logic         a_prev,
  input  logic [W-1:0] b,
  output logic [W-1:0] db
);

  booth_digit_e digit;

  always_comb begin
    digit = booth_decode(a_cur, a_prev);
    case (digit)
      DIGIT_POS: db = b;
      DIGIT_NEG: db = -b;
      default:   db = '0;
    endcase
  end

endmodule

// File: rtl/axc_booth_mul.sv
// Sequential approximate Booth multiplier: consumes Booth digits of A
// MSB-first, one per clock, stopping at the cycle budget or early.
module axc_booth_mul
  import axc_booth_pkg::*;
#(
  parameter int NA = 8,
  parameter int NB = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [NA-1:0]        A_in,
  input  logic [NB-1:0]        B_in,
  input  logic [$clog2(NA):0]  C_in,
  output logic [NA+NB-1:0]     N_out,
  output logic                 Done_out
);

  localparam int W  = NA + NB;
  localparam int CW = $clog2(NA) + 1;
  localparam int IW = $clog2(NA);

  state_e        state_q, state_d;
  logic [NA-1:0] a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  p_q, p_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] k_q, k_d;
  logic [W-1:0]  n_q, n_d;
  logic          done_q, done_d;

  logic          a_cur, a_prev;
  logic [W-1:0]  db;
  logic [W-1:0]  p_new;
  logic [CW-1:0] cnt_new;
  logic [CW-1:0] shamt;
  logic [NA-1:0] low_mask;
  logic          rest_zero;
  logic          finish;

  assign a_cur  = a_q[idx_q];
  assign a_prev = (idx_q == '0) ? 1'b0 : a_q[idx_q - 1'b1];

  booth_r2_digit #(.W(W)) u_digit (
    .a_cur  (a_cur),
    .a_prev (a_prev),
    .b      (b_q),
    .db     (db)
  );

  // Datapath for the digit being processed this edge, plus finish detection
  always_comb begin
    p_new     = (p_q << 1) + db;
    cnt_new   = cnt_q + 1'b1;
    low_mask  = ~({NA{1'b1}} << idx_q);
    rest_zero = ((a_q & low_mask) == '0);
    finish    = (cnt_new == k_q) || rest_zero || (idx_q == '0);
    shamt     = CW'(NA) - cnt_new;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    n_d     = n_q;
    done_d  = done_q;

    if (START) begin
      a_d     = A_in;
      b_d     = {{NA{B_in[NB-1]}}, B_in};
      k_d     = ((C_in == '0) || (C_in > CW'(NA))) ? CW'(NA) : C_in;
      p_d     = '0;
      idx_d   = IW'(NA - 1);
      cnt_d   = '0;
      done_d  = 1'b0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          p_d   = p_new;
          idx_d = idx_q - 1'b1;
          cnt_d = cnt_new;
          if (finish) begin
            // Scale the partial sum back to the weight of the unprocessed digits
            n_d     = p_new << shamt;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      n_q     <= n_d;
      done_q  <= done_d;
    end
  end

  assign N_out    = n_q;
  assign Done_out = done_q;

endmodule

// File: tb/tb_axc_booth_mul.sv
// Self-checking bench for axc_booth_mul: arithmetic rounding model checked
// every cycle, plus directed vectors with hand-computed products.
module tb_axc_booth_mul;

  localparam int NA = 8;
  localparam int NB = 8;
  localparam int W  = NA + NB;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [NA-1:0] A_in = '0;
  logic [NB-1:0] B_in = '0;
  logic [3:0]    C_in = '0;
  logic [W-1:0]  N_out;
  logic          Done_out;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  logic [W-1:0] m_n       = '0;
  logic         m_done    = 1'b0;
  logic [W-1:0] m_pending = '0;
  int           m_left    = 0;

  axc_booth_mul #(.NA(NA), .NB(NB)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .A_in     (A_in),
    .B_in     (B_in),
    .C_in     (C_in),
    .N_out    (N_out),
    .Done_out (Done_out)
  );

  always #5 CLK = ~CLK;

  // Result = B * (A rounded half-up to a multiple of 2^(NA-n)); n is the
  // budget, shortened when A's trailing zeros make the remaining digits zero.
  function automatic logic [W-1:0] model_product(input int a, input int b, input int c,
                                                 output int n);
    int k, tz, n_exit, approx, sh;
    k  = (c == 0 || c > NA) ? NA : c;
    tz = NA;
    for (int j = NA - 1; j >= 0; j--)
      if ((a & (1 << j)) != 0) tz = j;
    n_exit = (tz >= NA - 1) ? 1 : NA - tz;
    n = (k < n_exit) ? k : n_exit;
    if (n == NA) begin
      approx = a;
    end else begin
      sh     = NA - n;
      approx = ((a >>> (sh - 1)) + 1) >>> 1;
      approx = approx * (1 << sh);
    end
    return W'(approx * b);
  endfunction

  always @(posedge CLK) begin
    int n;
    if (RST) begin
      m_n    = '0;
      m_done = 1'b0;
      m_left = 0;
    end else if (START) begin
      m_pending = model_product(int'($signed(A_in)), int'($signed(B_in)), int'(C_in), n);
      m_left    = n;
      m_done    = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_n    = m_pending;
        m_done = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      compared++;
      if (N_out !== m_n || Done_out !== m_done) begin
        mismatched++;
        $display("[TB] FAIL model t=%0t: N_out=%h Done_out=%b, required N_out=%h Done_out=%b",
                 $time, N_out, Done_out, m_n, m_done);
      end
    end
  end

  task automatic check_output(input string name, input logic [W-1:0] exp_n, input logic exp_done);
    compared++;
    if (N_out !== exp_n || Done_out !== exp_done) begin
      mismatched++;
      $display("[TB] FAIL %s: N_out=%h Done_out=%b, required N_out=%h Done_out=%b",
               name, N_out, Done_out, exp_n, exp_done);
    end
  endtask

  task automatic apply_stimulus(input int a, input int b, input int c);
    @(negedge CLK);
    A_in  = NA'(a);
    B_in  = NB'(b);
    C_in  = 4'(c);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic run_op(input string name, input int a, input int b, input int c,
                        input logic [W-1:0] exp_n);
    apply_stimulus(a, b, c);
    repeat (13) @(negedge CLK);
    check_output(name, exp_n, 1'b1);
  endtask

  task automatic check_latency(input string name, input int a, input int b, input int c,
                               input int exp_edges, input logic [W-1:0] exp_n);
    int edges;
    apply_stimulus(a, b, c);
    edges = 0;
    while (!Done_out && edges < 20) begin
      @(negedge CLK);
      edges++;
    end
    compared++;
    if (edges != exp_edges) begin
      mismatched++;
      $display("[TB] FAIL %s latency: %0d edges, required %0d", name, edges, exp_edges);
    end
    check_output(name, exp_n, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_output("reset", 16'h0000, 1'b0);
    check_en = 1'b1;

    run_op("c8 -1x7",    -1,   7,  8, 16'hFFF9);
    run_op("c8 44x2",    44,   2,  8, 16'd88);
    run_op("c8 -27x80",  -27,  80, 8, 16'hF790);
    run_op("c8 -127x0",  -127, 0,  8, 16'h0000);
    run_op("c8 127x127", 127,  127, 8, 16'd16129);
    run_op("c8 85x4",    85,   4,  8, 16'd340);
    run_op("c8 -86x4",   -86,  4,  8, 16'hFEA8);

    run_op("c4 127x127", 127,  127, 4, 16'd16256);
    run_op("c4 85x4",    85,   4,  4, 16'd320);
    run_op("c4 -86x4",   -86,  4,  4, 16'hFEC0);
    run_op("c4 -1x7",    -1,   7,  4, 16'h0000);

    run_op("c1 85x4",    85,   4,  1, 16'd512);
    run_op("c1 44x2",    44,   2,  1, 16'h0000);
    run_op("c1 -27x80",  -27,  80, 1, 16'h0000);

    check_latency("early 44x2", 44, 2, 8, 6, 16'd88);
    check_latency("early 0x5",  0,  5, 8, 1, 16'h0000);
    check_latency("full 85x4",  85, 4, 8, 8, 16'd340);

    run_op("c0 -86x4",   -86, 4, 0,  16'hFEA8);
    run_op("c15 127x127", 127, 127, 15, 16'd16129);

    // Restart mid-operation: second operands win
    apply_stimulus(127, 127, 8);
    repeat (2) @(negedge CLK);
    check_output("busy keeps N_out", 16'd16129, 1'b0);
    run_op("restart -27x80", -27, 80, 8, 16'hF790);

    // Hold across idle cycles
    repeat (10) @(negedge CLK);
    check_output("hold", 16'hF790, 1'b1);

    // Reset mid-run
    apply_stimulus(127, 127, 8);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_output("reset mid-run", 16'h0000, 1'b0);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    check_output("idle after reset", 16'h0000, 1'b0);

    run_op("after reset 85x4", 85, 4, 4, 16'd320);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
